// File: rtl/pixel_array_pkg.sv
// Shared types and default constants for the pixel array controller.
package pixel_array_pkg;

  localparam int DEF_N_PIX      = 4;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_ERASE_CYC  = 5;
  localparam int DEF_EXPOSE_CYC = 255;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ERASE     = 3'd1,
    S_EXPOSE    = 3'd2,
    S_CONVERT   = 3'd3,
    S_RD_SETUP  = 3'd4,
    S_RD_SAMPLE = 3'd5,
    S_PUSH      = 3'd6
  } state_e;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ramp_counter.sv
// Up-counter shared by the erase, expose and ramp-ADC phases.
// Synchronous clear wins over enable; tc flags the last count of a phase.
module ramp_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, step, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign tc    = en && (cnt_q == last);

endmodule

// File: rtl/pixel_array_ctrl.sv
// Pixel array sequencer: erase, expose, ramp conversion on the shared bus,
// then one-pixel-at-a-time readout with a valid/ready output handshake.
module pixel_array_ctrl
  import pixel_array_pkg::*;
#(
  parameter int N_PIX      = DEF_N_PIX,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ERASE_CYC  = DEF_ERASE_CYC,
  parameter int EXPOSE_CYC = DEF_EXPOSE_CYC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     continuous,
  input  logic                     stop,
  output logic                     erase,
  output logic                     expose,
  output logic                     convert,
  output logic [N_PIX-1:0]         read,
  inout  wire  [DATA_W-1:0]        data,
  output logic [DATA_W-1:0]        pix_data,
  output logic [$clog2(N_PIX)-1:0] pix_idx,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int IDX_W = $clog2(N_PIX);
  // Wide enough for the ramp and for the longest timed phase.
  localparam int CNT_W = max_i(DATA_W, max_i($clog2(ERASE_CYC), $clog2(EXPOSE_CYC)));

  localparam logic [CNT_W-1:0] ERASE_LAST  = CNT_W'(ERASE_CYC - 1);
  localparam logic [CNT_W-1:0] EXPOSE_LAST = CNT_W'(EXPOSE_CYC - 1);
  localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'((1 << DATA_W) - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_PIX - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  pix_data_q, pix_data_d;
  logic [IDX_W-1:0]   pix_idx_q, pix_idx_d;
  logic               pix_valid_q, pix_valid_d;
  logic               frame_done_q, frame_done_d;
  logic               stop_pend_q, stop_pend_d;

  logic               cnt_clr;
  logic               cnt_en;
  logic [CNT_W-1:0]   cnt_last;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_tc;

  ramp_counter #(.W(CNT_W)) u_ramp (
    .clk   (clk),
    .rst_n (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .last  (cnt_last),
    .count (cnt),
    .tc    (cnt_tc)
  );

  // Next-state, readout capture, handshake and stop-request bookkeeping.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pix_data_d   = pix_data_q;
    pix_idx_d    = pix_idx_q;
    pix_valid_d  = pix_valid_q;
    frame_done_d = 1'b0;
    stop_pend_d  = stop_pend_q;
    cnt_en       = 1'b0;
    cnt_last     = ERASE_LAST;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ERASE;
      end
      S_ERASE: begin
        cnt_en   = 1'b1;
        cnt_last = ERASE_LAST;
        if (cnt_tc) state_d = S_EXPOSE;
      end
      S_EXPOSE: begin
        cnt_en   = 1'b1;
        cnt_last = EXPOSE_LAST;
        if (cnt_tc) state_d = S_CONVERT;
      end
      S_CONVERT: begin
        cnt_en   = 1'b1;
        cnt_last = CONV_LAST;
        if (cnt_tc) begin
          state_d = S_RD_SETUP;
          idx_d   = '0;
        end
      end
      S_RD_SETUP: begin
        state_d = S_RD_SAMPLE;
      end
      S_RD_SAMPLE: begin
        pix_data_d  = data;
        pix_idx_d   = idx_q;
        pix_valid_d = 1'b1;
        state_d     = S_PUSH;
      end
      S_PUSH: begin
        if (pix_ready) begin
          pix_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            frame_done_d = 1'b1;
            // A stop arriving on this very cycle still cancels the restart.
            state_d = (continuous && !(stop_pend_q || stop)) ? S_ERASE : S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_RD_SETUP;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_IDLE) begin
      stop_pend_d = 1'b0;
    end else if (stop && (state_q != S_IDLE)) begin
      stop_pend_d = 1'b1;
    end

    // Each phase starts its count from zero.
    cnt_clr = (state_d != state_q);
  end

  // Control and readout registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      pix_data_q   <= '0;
      pix_idx_q    <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      stop_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pix_data_q   <= pix_data_d;
      pix_idx_q    <= pix_idx_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
      stop_pend_q  <= stop_pend_d;
    end
  end

  // Strobes decode from the registered state so they are mutually exclusive.
  always_comb begin
    erase   = (state_q == S_ERASE);
    expose  = (state_q == S_EXPOSE);
    convert = (state_q == S_CONVERT);
    busy    = (state_q != S_IDLE);
    read    = '0;
    if ((state_q == S_RD_SETUP) || (state_q == S_RD_SAMPLE)) begin
      read = N_PIX'(1) << idx_q;
    end
  end

  // The ramp owns the bus only during conversion; pixels drive it on read.
  assign data = (state_q == S_CONVERT) ? cnt[DATA_W-1:0] : {DATA_W{1'bz}};

  assign pix_data   = pix_data_q;
  assign pix_idx    = pix_idx_q;
  assign pix_valid  = pix_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Directed bench for pixel_array_ctrl with a ramp-comparator pixel model.
module tb_pixel_array_ctrl;

  localparam int N_PIX = 4;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, continuous, stop, pix_ready;
  logic          erase, expose, convert, pix_valid, busy, frame_done;
  logic [N_PIX-1:0] read;
  wire  [DW-1:0] data;
  logic [DW-1:0] pix_data;
  logic [1:0]    pix_idx;

  pixel_array_ctrl #(
    .N_PIX(N_PIX), .DATA_W(DW), .ERASE_CYC(5), .EXPOSE_CYC(10)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .stop(stop),
    .erase(erase), .expose(expose), .convert(convert), .read(read), .data(data),
    .pix_data(pix_data), .pix_idx(pix_idx), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pixel model: each pixel latches the ramp when it reaches its level.
  logic [DW-1:0] code [N_PIX] = '{8'h33, 8'h66, 8'h99, 8'hCC};
  logic [DW-1:0] lat  [N_PIX];
  logic          drv_en;
  logic [DW-1:0] drv_val;

  always @(negedge clk)
    for (int i = 0; i < N_PIX; i++)
      if (convert && data == code[i]) lat[i] = data;

  always_comb begin
    drv_en  = |read;
    drv_val = '0;
    for (int i = 0; i < N_PIX; i++)
      if (read[i]) drv_val = lat[i];
  end

  assign data = drv_en ? drv_val : {DW{1'bz}};

  // Cycle counter and activity monitor.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int erase_n, expose_n, conv_n, fd_n, acc_n, first_valid, start_cyc;
  logic [DW-1:0] acc_dat [16];
  logic [1:0]    acc_idx [16];
  int            acc_cyc [16];
  logic          bus_idle;

  assign bus_idle = (data === {DW{1'bz}}) || (data === {DW{1'b0}});

  always @(negedge clk) begin
    if (reset) begin
      erase_n  += int'(erase);
      expose_n += int'(expose);
      conv_n   += int'(convert);
      if (frame_done) fd_n++;
      if (pix_valid && first_valid < 0) first_valid = cyc;
      if (pix_valid && pix_ready) begin
        if (acc_n < 16) begin
          acc_dat[acc_n] = pix_data;
          acc_idx[acc_n] = pix_idx;
          acc_cyc[acc_n] = cyc;
        end
        acc_n++;
      end
    end
    check("strobe_excl", 32'($countones({erase, expose, convert, |read}) <= 1), 32'd1);
    check("read_onehot0", 32'($onehot0(read)), 32'd1);
    if (!convert && read == '0) check("data_hiz", 32'(bus_idle), 32'd1);
  end

  task automatic clear_stats();
    erase_n = 0; expose_n = 0; conv_n = 0; fd_n = 0; acc_n = 0; first_valid = -1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    for (int i = 0; i < N_PIX; i++) lat[i] = '0;
    start = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int budget);
    int c;
    c = 0;
    while (fd_n < target && c < budget) begin
      @(posedge clk); c++;
    end
    check("fd_wait", 32'(fd_n >= target), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input int base, input string tag);
    for (int i = 0; i < N_PIX; i++) begin
      check({tag, "_idx"}, 32'(acc_idx[base + i]), 32'(i));
      check({tag, "_dat"}, 32'(acc_dat[base + i]), 32'(code[i]));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_strb"},  32'({erase, expose, convert}), 32'd0);
    check({tag, "_read"},  32'(read), 32'd0);
    check({tag, "_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_fd"},    32'(frame_done), 32'd0);
    check({tag, "_pdata"}, 32'(pix_data), 32'd0);
    check({tag, "_pidx"},  32'(pix_idx), 32'd0);
    check({tag, "_hiz"},   32'(bus_idle), 32'd1);
  endtask

  initial begin
    int c;
    reset = 1'b0; start = 1'b0; continuous = 1'b0; stop = 1'b0; pix_ready = 1'b1;
    clear_stats();
    idle_cycles(3);
    check_reset_vals("rst");
    reset = 1'b1;
    idle_cycles(2);

    // Single frame, ready always high.
    clear_stats();
    pulse_start();
    wait_fd(1, 1000);
    idle_cycles(5);
    check("t1_erase",   32'(erase_n),  32'd5);
    check("t1_expose",  32'(expose_n), 32'd10);
    check("t1_convert", 32'(conv_n),   32'd256);
    check("t1_latency", 32'(first_valid - start_cyc), 32'd273);
    check("t1_acc",     32'(acc_n), 32'd4);
    check("t1_fd",      32'(fd_n),  32'd1);
    check("t1_rate",    32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    check("t1_rate3",   32'(acc_cyc[3] - acc_cyc[2]), 32'd3);
    check("t1_busy",    32'(busy), 32'd0);
    check_frame(0, "t1");

    // Backpressure on pixel 2.
    clear_stats();
    pulse_start();
    c = 0;
    do begin @(negedge clk); c++; end while (!(pix_valid && pix_idx == 2'd1) && c < 1000);
    check("t2_wait1", 32'(c < 1000), 32'd1);
    @(posedge clk); #1;
    pix_ready = 1'b0;
    c = 0;
    do begin @(negedge clk); c++; end while (!pix_valid && c < 20);
    check("t2_wait2", 32'(c < 20), 32'd1);
    for (int k = 0; k < 7; k++) begin
      check("t2_hold_idx",   32'(pix_idx), 32'd2);
      check("t2_hold_dat",   32'(pix_data), 32'h99);
      check("t2_hold_valid", 32'(pix_valid), 32'd1);
      check("t2_hold_read",  32'(read), 32'd0);
      if (k < 6) @(negedge clk);
    end
    pix_ready = 1'b1;
    wait_fd(1, 200);
    idle_cycles(5);
    check("t2_acc", 32'(acc_n), 32'd4);
    check("t2_fd",  32'(fd_n),  32'd1);
    check_frame(0, "t2");

    // Continuous mode, stop during frame 2.
    clear_stats();
    continuous = 1'b1;
    pulse_start();
    c = 0;
    do begin @(negedge clk); c++; end while (!frame_done && c < 1000);
    check("t3_fd1_seen", 32'(c < 1000), 32'd1);
    check("t3_restart_erase", 32'(erase), 32'd1);
    check("t3_restart_busy",  32'(busy), 32'd1);
    idle_cycles(20);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_fd(2, 1000);
    idle_cycles(400);
    check("t3_fd",     32'(fd_n), 32'd2);
    check("t3_busy",   32'(busy), 32'd0);
    check("t3_erase",  32'(erase_n), 32'd10);
    check("t3_acc",    32'(acc_n), 32'd8);
    check_frame(4, "t3");
    continuous = 1'b0;

    // Start pulsed during conversion is ignored.
    clear_stats();
    pulse_start();
    c = 0;
    do begin @(negedge clk); c++; end while (!convert && c < 100);
    check("t4_conv_seen", 32'(c < 100), 32'd1);
    idle_cycles(10);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_fd(1, 1000);
    idle_cycles(400);
    check("t4_fd",      32'(fd_n), 32'd1);
    check("t4_convert", 32'(conv_n), 32'd256);
    check("t4_erase",   32'(erase_n), 32'd5);
    check("t4_acc",     32'(acc_n), 32'd4);
    check_frame(0, "t4");

    // Reset at ramp count 100.
    clear_stats();
    pulse_start();
    c = 0;
    do begin @(negedge clk); c++; end while (!(convert && data == 8'd100) && c < 500);
    check("t5_cnt100", 32'(c < 500), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_vals("t5_rst");
    idle_cycles(3);
    reset = 1'b1;
    idle_cycles(300);
    check("t5_no_fd",   32'(fd_n), 32'd0);
    check("t5_idle",    32'(busy), 32'd0);
    clear_stats();
    pulse_start();
    wait_fd(1, 1000);
    idle_cycles(5);
    check("t5_latency", 32'(first_valid - start_cyc), 32'd273);
    check("t5_fd",      32'(fd_n), 32'd1);
    check("t5_acc",     32'(acc_n), 32'd4);
    check_frame(0, "t5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
